// File: rtl/npu_pkg.sv
// Shared types and sizing for the layer-1/2 memory read controller.
package npu_pkg;

    localparam int DATA_W          = 8;
    localparam int IMG_ADDR_W      = 10;
    localparam int STORE_ADDR_W    = 14;
    localparam int PARAM_ADDR_W    = 15;

    localparam int IMG_W           = 32;
    localparam int NUM_BANDS       = 32;
    localparam int PARAM_WORDS     = 16;
    localparam int NUM_FILTERS     = 8;

    localparam int COL_W           = $clog2(IMG_W);
    localparam int BAND_W          = $clog2(NUM_BANDS);
    localparam int K_W             = $clog2(PARAM_WORDS);
    localparam int FILT_W          = $clog2(NUM_FILTERS);
    localparam int WRITES_PER_PASS = (IMG_W - 3) * NUM_BANDS;

    typedef enum logic [2:0] {
        IDLE,
        PARAM,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [IMG_ADDR_W-1:0] image_addr(input logic [BAND_W-1:0] band,
                                                         input logic [COL_W-1:0]  col);
        return IMG_ADDR_W'(band) * IMG_ADDR_W'(IMG_W) + IMG_ADDR_W'(col);
    endfunction

    function automatic logic [PARAM_ADDR_W-1:0] param_addr(input logic [FILT_W-1:0] filter,
                                                           input logic [K_W-1:0]    k);
        return PARAM_ADDR_W'(filter) * PARAM_ADDR_W'(PARAM_WORDS) + PARAM_ADDR_W'(k);
    endfunction

endpackage

// File: rtl/memory_read_layer12_if.sv
// RAM-side bus of the controller: image/param read ports, write-back strobes and FSM state.
// Read data is valid one cycle after its address; wr_en is a fire-and-forget strobe with no ready.
interface memory_read_layer12_if;
    import npu_pkg::*;

    logic [DATA_W-1:0]       read_image0;
    logic [DATA_W-1:0]       read_image1;
    logic [DATA_W-1:0]       read_image2;
    logic [DATA_W-1:0]       read_image3;
    logic [DATA_W-1:0]       read_conv;
    logic [IMG_ADDR_W-1:0]   image_ram_addr;
    logic [PARAM_ADDR_W-1:0] conv_ram_addr;
    logic [FILT_W-1:0]       ram_num;
    logic                    start_write_back;
    logic                    stop_write_back;
    logic                    wr_en;
    logic [STORE_ADDR_W-1:0] ram_store_addr;
    state_t                  state;

    modport master (
        input  read_image0, read_image1, read_image2, read_image3, read_conv,
        output image_ram_addr, conv_ram_addr, ram_num, start_write_back,
        output stop_write_back, wr_en, ram_store_addr, state
    );

    modport slave (
        output read_image0, read_image1, read_image2, read_image3, read_conv,
        input  image_ram_addr, conv_ram_addr, ram_num, start_write_back,
        input  stop_write_back, wr_en, ram_store_addr, state
    );

endinterface

// File: rtl/window_4x4.sv
// 4x4 byte sliding window: each load shifts every row one column older and inserts a new column.
module window_4x4
    import npu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     shift_en,
    input  logic [3:0][DATA_W-1:0]   col_in,
    output logic [15:0][DATA_W-1:0]  win
);

    logic [15:0][DATA_W-1:0] win_q;
    logic [15:0][DATA_W-1:0] win_d;

    always_comb begin
        win_d = win_q;
        if (shift_en) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_d[4*r+c] = win_q[4*r+c+1];
                end
                win_d[4*r+3] = col_in[r];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) win_q <= '0;
        else     win_q <= win_d;
    end

    assign win = win_q;

endmodule

// File: rtl/memory_read_layer12.sv
// Layer-1/2 read controller: per filter, fetch params, then stream the banked image through a
// 4x4 window and strobe one write-back per complete window into RAM ram_num.
module memory_read_layer12
    import npu_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    memory_read_layer12_if.master     bus,
    output logic [DATA_W-1:0]         out0,
    output logic [DATA_W-1:0]         out1,
    output logic [DATA_W-1:0]         out2,
    output logic [DATA_W-1:0]         out3,
    output logic [DATA_W-1:0]         out_param,
    output logic [DATA_W-1:0]         u0,  u1,  u2,  u3,
    output logic [DATA_W-1:0]         u4,  u5,  u6,  u7,
    output logic [DATA_W-1:0]         u8,  u9,  u10, u11,
    output logic [DATA_W-1:0]         u12, u13, u14, u15,
    output logic [STORE_ADDR_W-1:0]   ram_addr_a_test,
    output logic [STORE_ADDR_W-1:0]   ram_addr_b_test
);

    state_t                   state_q, state_d;
    logic [K_W-1:0]           k_q, k_d;
    logic [FILT_W-1:0]        filter_q, filter_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [BAND_W-1:0]        band_q, band_d;
    logic                     drain_q, drain_d;
    logic                     tag_valid_q, tag_valid_d;
    logic [COL_W-1:0]         tag_col_q, tag_col_d;
    logic [STORE_ADDR_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [STORE_ADDR_W-1:0]  ram_store_addr_q, ram_store_addr_d;
    logic                     wr_en_q, wr_en_d;
    logic                     start_q, start_d;
    logic                     stop_q, stop_d;
    logic [3:0][DATA_W-1:0]   out_q, out_d;
    logic [DATA_W-1:0]        out_param_q, out_param_d;
    logic [3:0][DATA_W-1:0]   img_col;
    logic [15:0][DATA_W-1:0]  win;

    assign img_col = {bus.read_image3, bus.read_image2, bus.read_image1, bus.read_image0};

    always_comb begin
        state_d          = state_q;
        k_d              = k_q;
        filter_d         = filter_q;
        col_d            = col_q;
        band_d           = band_q;
        drain_d          = drain_q;
        wr_cnt_d         = wr_cnt_q;
        ram_store_addr_d = ram_store_addr_q;
        // The tag follows its address by one cycle so it lines up with the returned data.
        tag_valid_d      = (state_q == STREAM);
        tag_col_d        = col_q;
        wr_en_d          = tag_valid_q && (tag_col_q >= COL_W'(3));
        start_d          = wr_en_d && (wr_cnt_q == '0);
        stop_d           = wr_en_q && (ram_store_addr_q == STORE_ADDR_W'(WRITES_PER_PASS - 1));
        out_d            = tag_valid_q ? img_col : out_q;
        out_param_d      = bus.read_conv;
        if (wr_en_d) begin
            ram_store_addr_d = wr_cnt_q;
            wr_cnt_d         = wr_cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: state_d = PARAM;
            PARAM: begin
                if (k_q == K_W'(PARAM_WORDS - 1)) state_d = STREAM;
                else                              k_d     = k_q + 1'b1;
            end
            STREAM: begin
                if (col_q == COL_W'(IMG_W - 1)) begin
                    if (band_q == BAND_W'(NUM_BANDS - 1)) begin
                        state_d = DRAIN;
                    end else begin
                        col_d  = '0;
                        band_d = band_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            // Two cycles: last data lands in the window, then its write strobe goes out.
            DRAIN: begin
                if (!drain_q) begin
                    drain_d = 1'b1;
                end else begin
                    drain_d = 1'b0;
                    if (filter_q == FILT_W'(NUM_FILTERS - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d          = PARAM;
                        filter_d         = filter_q + 1'b1;
                        k_d              = '0;
                        col_d            = '0;
                        band_d           = '0;
                        wr_cnt_d         = '0;
                        ram_store_addr_d = '0;
                    end
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            k_q              <= '0;
            filter_q         <= '0;
            col_q            <= '0;
            band_q           <= '0;
            drain_q          <= 1'b0;
            tag_valid_q      <= 1'b0;
            tag_col_q        <= '0;
            wr_cnt_q         <= '0;
            ram_store_addr_q <= '0;
            wr_en_q          <= 1'b0;
            start_q          <= 1'b0;
            stop_q           <= 1'b0;
            out_q            <= '0;
            out_param_q      <= '0;
        end else begin
            state_q          <= state_d;
            k_q              <= k_d;
            filter_q         <= filter_d;
            col_q            <= col_d;
            band_q           <= band_d;
            drain_q          <= drain_d;
            tag_valid_q      <= tag_valid_d;
            tag_col_q        <= tag_col_d;
            wr_cnt_q         <= wr_cnt_d;
            ram_store_addr_q <= ram_store_addr_d;
            wr_en_q          <= wr_en_d;
            start_q          <= start_d;
            stop_q           <= stop_d;
            out_q            <= out_d;
            out_param_q      <= out_param_d;
        end
    end

    window_4x4 u_window (
        .clk      (clk),
        .rst      (reset),
        .shift_en (tag_valid_q),
        .col_in   (img_col),
        .win      (win)
    );

    assign bus.image_ram_addr   = image_addr(band_q, col_q);
    assign bus.conv_ram_addr    = param_addr(filter_q, k_q);
    assign bus.ram_num          = filter_q;
    assign bus.start_write_back = start_q;
    assign bus.stop_write_back  = stop_q;
    assign bus.wr_en            = wr_en_q;
    assign bus.ram_store_addr   = ram_store_addr_q;
    assign bus.state            = state_q;

    assign ram_addr_a_test = ram_store_addr_q;
    assign ram_addr_b_test = {4'b0, bus.image_ram_addr};

    assign out0      = out_q[0];
    assign out1      = out_q[1];
    assign out2      = out_q[2];
    assign out3      = out_q[3];
    assign out_param = out_param_q;

    assign u0  = win[0];   assign u1  = win[1];   assign u2  = win[2];   assign u3  = win[3];
    assign u4  = win[4];   assign u5  = win[5];   assign u6  = win[6];   assign u7  = win[7];
    assign u8  = win[8];   assign u9  = win[9];   assign u10 = win[10];  assign u11 = win[11];
    assign u12 = win[12];  assign u13 = win[13];  assign u14 = win[14];  assign u15 = win[15];

endmodule

// File: tb/tb_memory_read_layer12.sv
// Bench for memory_read_layer12: random image/param RAM contents, cycle-schedule reference and
// a write scoreboard that rebuilds each expected window straight from the image array.
module tb_memory_read_layer12;
    import npu_pkg::*;

    localparam int PASS_CYC = PARAM_WORDS + IMG_W * NUM_BANDS + 2;
    localparam int RUN_CYC  = 1 + NUM_FILTERS * PASS_CYC + 120;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    memory_read_layer12_if bus ();

    logic [7:0]  o_img [4];
    logic [7:0]  out_param;
    logic [7:0]  u [16];
    logic [13:0] a_test, b_test;

    memory_read_layer12 dut (
        .clk (clk), .reset (reset), .bus (bus),
        .out0 (o_img[0]), .out1 (o_img[1]), .out2 (o_img[2]), .out3 (o_img[3]),
        .out_param (out_param),
        .u0 (u[0]),   .u1 (u[1]),   .u2 (u[2]),   .u3 (u[3]),
        .u4 (u[4]),   .u5 (u[5]),   .u6 (u[6]),   .u7 (u[7]),
        .u8 (u[8]),   .u9 (u[9]),   .u10 (u[10]), .u11 (u[11]),
        .u12 (u[12]), .u13 (u[13]), .u14 (u[14]), .u15 (u[15]),
        .ram_addr_a_test (a_test), .ram_addr_b_test (b_test)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0]  img [4][1024];
    logic [13:0] exp_q[$];
    int          n_checks;
    int          n_fail;
    int          t;
    int          wr_total;
    logic [7:0]  conv_prev;
    logic [9:0]  addr_s;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    // ---------------- RAM models (1-cycle read latency) ----------------
    initial begin
        bus.read_image0 = '0; bus.read_image1 = '0; bus.read_image2 = '0; bus.read_image3 = '0;
        bus.read_conv   = '0;
        conv_prev       = '0;
        addr_s          = '0;
        forever begin
            @(negedge clk);
            addr_s = bus.image_ram_addr;
            @(posedge clk);
            #1;
            conv_prev       = bus.read_conv;
            bus.read_image0 = img[0][addr_s];
            bus.read_image1 = img[1][addr_s];
            bus.read_image2 = img[2][addr_s];
            bus.read_image3 = img[3][addr_s];
            bus.read_conv   = 8'($urandom_range(0, 255));
        end
    end

    // ---------------- checks ----------------
    task automatic check_reset_zero(input string tag);
        logic [127:0] win_obs;
        win_obs = '0;
        for (int i = 0; i < 16; i++) win_obs[i*8 +: 8] = u[i];
        check({tag, "_state"}, 128'(bus.state), 128'(IDLE));
        check({tag, "_img_addr"}, 128'(bus.image_ram_addr), 128'(0));
        check({tag, "_conv_addr"}, 128'(bus.conv_ram_addr), 128'(0));
        check({tag, "_wb_flags"}, 128'({bus.wr_en, bus.start_write_back, bus.stop_write_back}), 128'(0));
        check({tag, "_ram_num"}, 128'(bus.ram_num), 128'(0));
        check({tag, "_store_addr"}, 128'({bus.ram_store_addr, a_test, b_test}), 128'(0));
        check({tag, "_outs"}, 128'({o_img[3], o_img[2], o_img[1], o_img[0], out_param}), 128'(0));
        check({tag, "_window"}, win_obs, 128'(0));
    endtask

    task automatic check_write();
        logic [13:0]  n;
        int           b, c, base;
        logic [127:0] win_obs, win_exp;
        logic [31:0]  out_obs, out_exp;
        if (exp_q.size() == 0) begin
            check("wr_extra", 128'(1), 128'(0));
            return;
        end
        n    = exp_q.pop_front();
        b    = int'(n) / (IMG_W - 3);
        c    = int'(n) % (IMG_W - 3) + 3;
        base = b * IMG_W + c - 3;
        win_obs = '0; win_exp = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                win_obs[(4*r+j)*8 +: 8] = u[4*r+j];
                win_exp[(4*r+j)*8 +: 8] = img[r][10'(base + j)];
            end
            out_obs[r*8 +: 8] = o_img[r];
            out_exp[r*8 +: 8] = img[r][10'(base + 3)];
        end
        check("store_addr", 128'(bus.ram_store_addr), 128'(n));
        check("addr_a_test", 128'(a_test), 128'(n));
        check("window", win_obs, win_exp);
        check("out_col", 128'(out_obs), 128'(out_exp));
        wr_total++;
    endtask

    // Expected behaviour at cycle t (t active edges after reset release) from the pass schedule.
    task automatic check_cycle();
        state_t st;
        int     p, o, s, idx;
        logic   exp_wr, exp_stop;
        idx = t - 1;
        p   = idx / PASS_CYC;
        o   = idx % PASS_CYC;
        if (p >= NUM_FILTERS) begin
            st = DONE;
            p  = NUM_FILTERS - 1;
            o  = PASS_CYC;
        end else if (o < PARAM_WORDS) begin
            st = PARAM;
        end else if (o < PARAM_WORDS + IMG_W * NUM_BANDS) begin
            st = STREAM;
        end else begin
            st = DRAIN;
        end

        check("state", 128'(bus.state), 128'(st));
        check("ram_num", 128'(bus.ram_num), 128'(p));
        check("out_param", 128'(out_param), 128'(conv_prev));
        if (st == PARAM) begin
            check("conv_addr", 128'(bus.conv_ram_addr), 128'(p * PARAM_WORDS + o));
            if (o == 0) begin
                for (int i = 0; i < WRITES_PER_PASS; i++) exp_q.push_back(14'(i));
            end
        end
        if (st == STREAM) begin
            check("img_addr", 128'(bus.image_ram_addr), 128'(o - PARAM_WORDS));
            check("addr_b_test", 128'(b_test), 128'(o - PARAM_WORDS));
        end

        s        = o - PARAM_WORDS - 2;
        exp_wr   = (st == STREAM || st == DRAIN) && s >= 0 && (s % IMG_W) >= 3;
        exp_stop = idx > 0 && (idx % PASS_CYC) == 0 && (idx / PASS_CYC) <= NUM_FILTERS;
        check("wr_en", 128'(bus.wr_en), 128'(exp_wr));
        check("start_wb", 128'(bus.start_write_back), 128'(exp_wr && s == 3));
        check("stop_wb", 128'(bus.stop_write_back), 128'(exp_stop));
        if (bus.wr_en) check_write();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        t        = 0;
        wr_total = 0;
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 1024; a++) img[r][a] = 8'($urandom_range(0, 255));
        end

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_zero("por");
        reset = 1'b0;

        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            t++;
            @(negedge clk);
            check_cycle();
        end

        // Asynchronous reset in the middle of streaming.
        #2 reset = 1'b1;
        #1 check_reset_zero("mid");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        t        = 0;
        wr_total = 0;

        for (int i = 0; i < RUN_CYC; i++) begin
            @(posedge clk);
            t++;
            @(negedge clk);
            check_cycle();
        end

        check("writes_total", 128'(wr_total), 128'(NUM_FILTERS * WRITES_PER_PASS));
        check("queue_empty", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
